// File: rtl/spfp_pkg.sv
// Shared single-precision FP types and constants for the ALU datapath.
package spfp_pkg;
  localparam int          BIAS     = 127;
  localparam int          EXP_MAX  = 255;
  localparam int          UP_EXP_W = 10;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } spfp_flags_t;

  // Unnormalised result as produced by the add/sub significand datapath.
  typedef struct packed {
    logic                sign;
    logic [UP_EXP_W-1:0] exp;
    logic [27:0]         sig;
    logic                nan;
    logic                inf;
  } unpacked_t;
endpackage

// File: rtl/spfp_lzc27.sv
// Combinational leading-zero counter over 27 bits (all-zero input yields 0).
module spfp_lzc27 (
  input  logic [26:0] a_i,
  output logic [4:0]  cnt_o
);
  logic found;

  // Priority scan from the MSB; first set bit fixes the count.
  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && a_i[i]) begin
        cnt_o = 5'(26 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spfp_norm_round.sv
// Post-add normalise / round-to-nearest-even / pack stage, two pipeline stages.
module spfp_norm_round
  import spfp_pkg::*;
#(
  parameter int EXP_W         = 10,
  parameter bit FLUSH_SUBNORM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [27:0]      in_sig,
  input  logic             in_nan,
  input  logic             in_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inx
);
  unpacked_t in_u;
  assign in_u = '{sign: in_sign, exp: in_exp, sig: in_sig, nan: in_nan, inf: in_inf};

  // Handshake: each stage advances when its downstream slot is free.
  logic s1_valid_q, s2_valid_q;
  logic adv1, adv2;
  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;

  // ---------------- Stage 1: normalise ----------------
  logic [4:0]       lz;
  logic [26:0]      sh;
  logic [23:0]      m_d, m_q;
  logic             g_d, r_d, s_d, g_q, r_q, s_q;
  logic [EXP_W-1:0] exp_d, exp_q;
  logic             zero_d, zero_q, sign_q, nan_q, inf_q;

  spfp_lzc27 u_lzc (.a_i(in_u.sig[26:0]), .cnt_o(lz));

  assign sh = in_u.sig[26:0] << lz;

  // Carry-out shifts right one (folding the dropped bit into sticky), else left by lz.
  always_comb begin
    zero_d = (in_u.sig == 28'd0);
    if (in_u.sig[27]) begin
      m_d   = in_u.sig[27:4];
      g_d   = in_u.sig[3];
      r_d   = in_u.sig[2];
      s_d   = in_u.sig[1] | in_u.sig[0];
      exp_d = in_u.exp + EXP_W'(1);
    end else begin
      m_d   = sh[26:3];
      g_d   = sh[2];
      r_d   = sh[1];
      s_d   = sh[0];
      exp_d = in_u.exp - EXP_W'(lz);
    end
  end

  // Stage 1 register: loads on every accepted input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      m_q        <= '0;
      {g_q, r_q, s_q} <= '0;
      exp_q      <= '0;
      {zero_q, sign_q, nan_q, inf_q} <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        m_q    <= m_d;
        g_q    <= g_d;
        r_q    <= r_d;
        s_q    <= s_d;
        exp_q  <= exp_d;
        zero_q <= zero_d;
        sign_q <= in_u.sign;
        nan_q  <= in_u.nan;
        inf_q  <= in_u.inf;
      end
    end
  end

  // ---------------- Stage 2: round and pack ----------------
  logic             up;
  logic [24:0]      m25;
  logic [22:0]      frac;
  logic [EXP_W-1:0] e2;
  logic [31:0]      z_d, z_q;
  spfp_flags_t      flags_d, flags_q;
  logic             unused_hidden;

  // Hidden bit is implied by the packed format and never stored.
  assign unused_hidden = m25[23];

  // RNE increment; a carry out of the mantissa renormalises by one.
  always_comb begin
    up   = g_q & (r_q | s_q | m_q[0]);
    m25  = {1'b0, m_q} + {24'b0, up};
    frac = m25[22:0];
    e2   = exp_q;
    if (m25[24]) begin
      frac = m25[23:1];
      e2   = exp_q + EXP_W'(1);
    end
    flags_d     = '0;
    flags_d.inx = g_q | r_q | s_q;
    z_d         = {sign_q, e2[7:0], frac};
    if (nan_q) begin
      z_d     = QNAN;
      flags_d = '0;
    end else if (inf_q) begin
      z_d     = {sign_q, 8'hFF, 23'b0};
      flags_d = '0;
    end else if (zero_q) begin
      z_d     = {sign_q, 31'b0};
      flags_d = '0;
    end else if ($signed(e2) >= $signed(EXP_W'(EXP_MAX))) begin
      z_d     = {sign_q, 8'hFF, 23'b0};
      flags_d = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
    end else if (FLUSH_SUBNORM && ($signed(e2) <= $signed(EXP_W'(0)))) begin
      // Only flush-to-zero is supported; subnormal outputs are never produced.
      z_d     = {sign_q, 31'b0};
      flags_d = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
    end
  end

  // Stage 2 register: holds the result while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      flags_q    <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        z_q     <= z_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_z   = z_q;
  assign out_ovf = flags_q.ovf;
  assign out_unf = flags_q.unf;
  assign out_inx = flags_q.inx;
endmodule

// File: tb/tb_spfp_norm_round.sv
// Directed bench for spfp_norm_round: vector table plus stall/reset sequences.
module tb_spfp_norm_round;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_sign, in_nan, in_inf;
  logic [9:0]  in_exp;
  logic [27:0] in_sig;
  logic        out_valid, out_ready, out_ovf, out_unf, out_inx;
  logic [31:0] out_z;

  always #5 clk = ~clk;

  spfp_norm_round #(.EXP_W(10), .FLUSH_SUBNORM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_nan(in_nan),
    .in_inf(in_inf), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_ovf(out_ovf), .out_unf(out_unf), .out_inx(out_inx)
  );

  // flags packed as {ovf, unf, inx}
  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] sig;
    logic        nan;
    logic        inf;
    logic [31:0] z;
    logic [2:0]  f;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic s, logic [9:0] e, logic [27:0] g, logic n, logic i,
                              logic [31:0] z, logic [2:0] f);
    vec_t v;
    v.sign = s; v.exp = e; v.sig = g; v.nan = n; v.inf = i; v.z = z; v.f = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign; in_exp = v.exp; in_sig = v.sig; in_nan = v.nan; in_inf = v.inf;
  endtask

  initial begin
    int   n, sent, recv;
    logic have_held;
    logic [31:0] held;
    vec_t bp[4];

    // identity, carry, rounding, overflow, specials, cancellation, flush, boundaries
    tv.push_back(mk(0, 10'd127, 28'h4000000, 0, 0, 32'h3F800000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h8000000, 0, 0, 32'h40000000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h4000004, 0, 0, 32'h3F800000, 3'b001));
    tv.push_back(mk(0, 10'd127, 28'h400000C, 0, 0, 32'h3F800002, 3'b001));
    tv.push_back(mk(1, 10'd127, 28'h4000006, 0, 0, 32'hBF800001, 3'b001));
    tv.push_back(mk(0, 10'd127, 28'h8000018, 0, 0, 32'h40000002, 3'b001));
    tv.push_back(mk(0, 10'd127, 28'h8000001, 0, 0, 32'h40000000, 3'b001));
    tv.push_back(mk(0, 10'd254, 28'h7FFFFFF, 0, 0, 32'h7F800000, 3'b101));
    tv.push_back(mk(0, 10'd255, 28'h4000000, 0, 0, 32'h7F800000, 3'b101));
    tv.push_back(mk(0, 10'd254, 28'h4000000, 0, 0, 32'h7F000000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h4000000, 1, 0, 32'h7FC00000, 3'b000));
    tv.push_back(mk(1, 10'd127, 28'h4000000, 1, 1, 32'h7FC00000, 3'b000));
    tv.push_back(mk(1, 10'd127, 28'h4000000, 0, 1, 32'hFF800000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h0000008, 0, 0, 32'h34000000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h0000018, 0, 0, 32'h34C00000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h0000001, 0, 0, 32'h32800000, 3'b000));
    tv.push_back(mk(0, 10'd127, 28'h0000000, 0, 0, 32'h00000000, 3'b000));
    tv.push_back(mk(1, 10'd3,   28'h0000000, 0, 0, 32'h80000000, 3'b000));
    tv.push_back(mk(0, 10'd5,   28'h0000008, 0, 0, 32'h00000000, 3'b011));
    tv.push_back(mk(0, 10'd1,   28'h4000000, 0, 0, 32'h00800000, 3'b000));
    tv.push_back(mk(1, 10'd0,   28'h4000000, 0, 0, 32'h80000000, 3'b011));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(tv[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_z", out_z, 32'h0);
    chk("rst_flags", 32'({out_ovf, out_unf, out_inx}), 32'd0);
    rst_n = 1'b1;

    // Table: one transaction at a time, checking latency, result and flags.
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd2);
      chk($sformatf("v%0d_z", i), out_z, tv[i].z);
      chk($sformatf("v%0d_flags", i), 32'({out_ovf, out_unf, out_inx}), 32'(tv[i].f));
    end

    // Backpressure: 4 inputs, consumer stalled for the first 5 cycles.
    bp[0] = tv[0]; bp[1] = tv[1]; bp[2] = tv[3]; bp[3] = tv[13];
    sent = 0; recv = 0; have_held = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) drive(bp[sent]);
      #1;
      if (cyc == 4) begin
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(sent), 32'd2);
      end
      if (out_valid && !out_ready) begin
        if (have_held) chk($sformatf("bp_hold_c%0d", cyc), out_z, held);
        held = out_z; have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", recv), out_z, bp[recv].z);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("bp_recv_count", 32'(recv), 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_no_dup%0d", c), 32'(out_valid), 32'd0);
    end

    // Reset with both stages occupied.
    out_ready = 1'b0;
    @(negedge clk);
    drive(tv[1]); in_valid = 1'b1;
    @(negedge clk);
    drive(tv[3]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full", 32'(out_valid & !in_ready), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_out_z", out_z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("mid_stale%0d", c), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spfp_norm_round.md
Name: spfp_norm_round

Overview:
- Post-add normalise/round stage for the single-precision ALU; sits directly downstream of the add/sub significand datapath.
- Accepts an unnormalised sign/exponent/significand triple with guard, round and sticky bits, normalises it, rounds to nearest-even, handles overflow/underflow and packs an IEEE-754 word.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- EXP_W, 10, width of the signed biased input exponent; holds the carry and cancellation range.
- FLUSH_SUBNORM, 1, fixed at 1; results below the normal range flush to signed zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  stage can accept input this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed biased exponent (bias 127), aligned to the hidden bit at sig[26]
- in_sig  in  28  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S
- in_nan  in  1  force quiet NaN
- in_inf  in  1  force signed infinity
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_z  out  32  packed IEEE-754 result
- out_ovf  out  1  overflow flag
- out_unf  out  1  underflow (flushed) flag
- out_inx  out  1  inexact flag

Behaviour:
- Reset (rst_n=0 at a clk edge): s1_valid=0, s2_valid=0, out_z=0, all flags=0, in_ready=1 in the following cycle. Reset mid-flight discards in-flight transactions; no partial output is produced.
- Handshake:
  - Input transfers when in_valid&in_ready.
  - Output transfers when out_valid&out_ready.
  - out_valid=s2_valid.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready; no combinational path from in_valid.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput 1/cycle. Bubbles collapse. Order is preserved; no loss or duplication.
- out_z and flags stay stable while out_valid&!out_ready.
- Stage 1 (normalise):
  - Carry case, sig[27]=1: shift right by 1; new S = sig[1]|sig[0]; exp+1.
  - Otherwise: lz = leading-zero count of sig[26:0] (0..26). Shift the 27-bit field left by lz, zero-filled; exp−lz.
  - sig[27:0]==0: zero flag set; exponent is don't-care.
  - Register the 24-bit mantissa m, G, R, S, exp, sign, zero, nan and inf.
- Stage 2 (round/pack):
  - RNE: up = G & (R | S | m[0]).
  - inexact = G|R|S.
  - m' = m + up (25 bits). If m'[24]=1: shift right by 1, exp+1.
  - Pack priority:
    - nan → 32'h7FC00000, flags 0.
    - inf → {sign, 8'hFF, 0}, flags 0.
    - zero → {sign, 31'b0}, flags 0.
    - exp ≥ 255 (signed) → {sign, 8'hFF, 0}, ovf=1, inx=1.
    - exp ≤ 0 → {sign, 31'b0}, unf=1, inx=1.
    - otherwise {sign, exp[7:0], m'[22:0]}, inx as computed.
  - All exponent arithmetic is signed EXP_W bits; the input range is guaranteed within −64..383.

Decomposition:
- Shared package spfp_pkg holds:
  - BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000.
  - typedef spfp_flags_t {ovf, unf, inx}.
  - typedef unpacked_t {sign, exp, sig[27:0], nan, inf}, later shared with the add/sub datapath.
- One sub-module: spfp_lzc27, a combinational leading-zero counter for 27 bits returning 5 bits.
- Pipeline registers and the rounding logic stay inline.

Test Plan:
- Identity: exp=127, sig=28'h4000000 → out_z=3F800000 after 2 cycles, flags 0.
- Carry: exp=127, sig=28'h8000000 → 40000000. Tie-even round-down: sig=28'h4000004 → 3F800000, inx=1. Round-up: sig=28'h400000C → 3F800002, inx=1.
- Overflow: exp=254, sig=28'h7FFFFFF → rounding carry to exp 255 → 7F800000, ovf=1, inx=1. Specials: in_nan → 7FC00000; in_inf with sign=1 → FF800000.
- Cancellation: exp=127, sig=28'h0000008 → lz=23 → 34000000. sig=0 with sign=0 → 00000000, flags 0. exp=5, sig=28'h0000008 → flush → 00000000, unf=1.
- Backpressure: stream 4 inputs with out_ready=0 for 5 cycles → in_ready drops after 2 accepted; on release, 4 results appear in order with no duplicates; out_z is held stable during the stall.
- Reset mid-flight: assert rst_n=0 with both stages valid → next cycle out_valid=0, in_ready=1; no stale result appears after deassert.
